fwd_hazard_unit: RTL

Parametrised forwarding and hazard unit for the in-order pipeline. It keeps its own shadow pipeline of destination tags for every stage after ID, and drives the per-operand EX bypass selects, the MEM-to-MEM store-data bypass and the load-use stall. It also counts stall cycles for performance monitoring. It sits beside the ID/EX pipeline register and replaces the fixed two-stage combinational forwarding logic.

---
 rtl/fwd_hazard_unit_pkg.sv | 30 +++
 rtl/fwd_hazard_unit_if.sv | 34 +++
 rtl/fwd_hazard_unit_match.sv | 38 +++
 rtl/fwd_hazard_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared tag type, select encodings and parameter legality check for fwd_hazard_unit.
package fwd_pkg;

  // Register fields in a tag are sized for the widest supported REG_W and zero-extended.
  localparam int FWD_RW = 8;

  localparam int FWD_SEL_RF  = 0;
  localparam int FWD_SEL_MEM = 1;
  localparam int FWD_SEL_WB  = 2;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [FWD_RW-1:0] dst;
    logic              is_load;
    logic              is_store;
    logic [FWD_RW-1:0] rs;
    logic [FWD_RW-1:0] rt;
    logic              rs_used;
    logic              rt_used;
  } fwd_tag_t;

  function automatic bit fwd_params_ok(int reg_w, int stages, int load_lat, int cnt_w);
    return (reg_w >= 1) && (reg_w <= FWD_RW) &&
           (stages >= 2) && (stages <= 7) &&
           (load_lat >= 1) && (load_lat <= stages - 1) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side request and forwarding/stall response bundle for fwd_hazard_unit.
interface fwd_hazard_unit_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_we;
  logic [REG_W-1:0] id_dst;
  logic             id_is_load;
  logic             id_is_store;
  logic             freeze;
  logic             flush;
  logic             stall;
  logic [2:0]       fwd_a_sel;
  logic [2:0]       fwd_b_sel;
  logic             mtom;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_dst,
           id_is_load, id_is_store, freeze, flush,
    input  stall, fwd_a_sel, fwd_b_sel, mtom, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_dst,
           id_is_load, id_is_store, freeze, flush,
    output stall, fwd_a_sel, fwd_b_sel, mtom, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Priority comparator: youngest slot (lowest index >= FIRST) writing src_i.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int N     = 3,
  parameter int FIRST = 0
) (
  input  logic [N-1:0]      wr_i,
  input  logic [FWD_RW-1:0] dst_i [N],
  input  logic [FWD_RW-1:0] src_i,
  output logic              hit_o,
  output logic [2:0]        idx_o
);
  logic [N-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cmp
      if (gi < FIRST) begin : g_skip
        assign match[gi] = 1'b0;
      end else begin : g_live
        assign match[gi] = wr_i[gi] & (dst_i[gi] == src_i) & (src_i != '0);
      end
    end
  endgenerate

  // Scan oldest to youngest so the youngest hit is the last assignment.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_o = 1'b1;
        idx_o = 3'(k);
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow tag pipeline driving EX bypass selects, load-use stall and stall counter.
// Define FWD_MTOM_EN to enable the MEM-to-MEM store-data bypass.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W    = 4,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_unit_if.slave bus
);
  generate
    if (!fwd_params_ok(REG_W, STAGES, LOAD_LAT, CNT_W)) begin : g_bad_params
      $error("fwd_hazard_unit: illegal parameter combination");
    end
  endgenerate

  fwd_tag_t          slot_q [STAGES];
  fwd_tag_t          slot_d [STAGES];
  fwd_tag_t          id_tag;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [STAGES-1:0] wr_v, ld_v;
  logic [FWD_RW-1:0] dst_v [STAGES];
  logic [7:0]        ld_pad;
  logic              hit_a, hit_b, hit_srs, hit_srt;
  logic [2:0]        idx_a, idx_b, idx_srs, idx_srt;
  logic              haz_rs, haz_rt, st_byp, stall;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_view
      assign wr_v[gi]  = slot_q[gi].valid & slot_q[gi].we;
      assign ld_v[gi]  = slot_q[gi].is_load;
      assign dst_v[gi] = slot_q[gi].dst;
    end
  endgenerate
  assign ld_pad = 8'(ld_v);

  // A write to r0 is recorded as no write at all so it can never match.
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = bus.id_valid;
    id_tag.we       = bus.id_we & (bus.id_dst != '0);
    id_tag.dst      = FWD_RW'(bus.id_dst);
    id_tag.is_load  = bus.id_is_load;
    id_tag.is_store = bus.id_is_store;
    id_tag.rs       = FWD_RW'(bus.id_rs);
    id_tag.rt       = FWD_RW'(bus.id_rt);
    id_tag.rs_used  = bus.id_rs_used;
    id_tag.rt_used  = bus.id_rt_used;
  end

  fwd_match #(.N(STAGES), .FIRST(1)) u_match_a (
    .wr_i(wr_v), .dst_i(dst_v), .src_i(slot_q[0].rs), .hit_o(hit_a), .idx_o(idx_a));
  fwd_match #(.N(STAGES), .FIRST(1)) u_match_b (
    .wr_i(wr_v), .dst_i(dst_v), .src_i(slot_q[0].rt), .hit_o(hit_b), .idx_o(idx_b));
  fwd_match #(.N(STAGES), .FIRST(0)) u_match_srs (
    .wr_i(wr_v), .dst_i(dst_v), .src_i(id_tag.rs), .hit_o(hit_srs), .idx_o(idx_srs));
  fwd_match #(.N(STAGES), .FIRST(0)) u_match_srt (
    .wr_i(wr_v), .dst_i(dst_v), .src_i(id_tag.rt), .hit_o(hit_srt), .idx_o(idx_srt));

  assign bus.fwd_a_sel = (hit_a & slot_q[0].rs_used) ? idx_a : 3'(FWD_SEL_RF);
  assign bus.fwd_b_sel = (hit_b & slot_q[0].rt_used) ? idx_b : 3'(FWD_SEL_RF);

  // Only the youngest writer matters: a younger ALU result shadows an older load.
  assign haz_rs = bus.id_valid & bus.id_rs_used & hit_srs & ld_pad[idx_srs] &
                  (({1'b0, idx_srs} + 4'd1) < 4'(LOAD_LAT));
  assign haz_rt = bus.id_valid & bus.id_rt_used & hit_srt & ld_pad[idx_srt] &
                  (({1'b0, idx_srt} + 4'd1) < 4'(LOAD_LAT));

`ifdef FWD_MTOM_EN
  assign st_byp   = bus.id_is_store;
  assign bus.mtom = slot_q[FWD_SEL_MEM].valid & slot_q[FWD_SEL_MEM].is_store &
                    wr_v[FWD_SEL_WB] & (dst_v[FWD_SEL_WB] == slot_q[FWD_SEL_MEM].rt) &
                    (slot_q[FWD_SEL_MEM].rt != '0);
`else
  assign st_byp   = 1'b0;
  assign bus.mtom = 1'b0;
`endif

  assign stall          = ~bus.flush & (haz_rs | (haz_rt & ~st_byp));
  assign bus.stall      = stall;
  assign bus.stall_cnt  = stall_cnt_q;

  always_comb begin
    slot_d      = slot_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.freeze) begin
      slot_d[0] = (stall | bus.flush | ~bus.id_valid) ? '0 : id_tag;
      for (int k = 1; k < STAGES; k++) begin
        slot_d[k] = slot_q[k-1];
      end
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
